// File: rtl/boid_accelerator_core.sv
// boid_accelerator_core
// Single-boid motion engine. Holds one boid's position and velocity in signed
// 16.16 fixed point and runs a five-step update: latch velocity, apply
// screen-margin turning, estimate speed (alpha-max-beta-min), clamp the speed,
// then move. The previous position is exported so the drawing logic can erase
// the old pixel.
//
// Ports:
//   clk    in   1   system clock, all state changes on the rising edge
//   reset  in   1   synchronous active-high reset, has priority over en
//   en     in   1   clock enable; FSM and all registers hold when low
//   x, y   out  32  current position, signed 16.16
//   vx, vy out  32  current velocity, signed 16.16
//   px, py out  32  position before the last update, signed 16.16
module boid_accelerator_core #(
    parameter int          LEFT_MARGIN   = 100,
    parameter int          RIGHT_MARGIN  = 540,
    parameter int          TOP_MARGIN    = 100,
    parameter int          BOTTOM_MARGIN = 380,
    parameter logic [31:0] TURN_FACTOR   = 32'h00003333,
    parameter logic [31:0] MAX_SPEED     = 32'h00060000,
    parameter logic [31:0] MIN_SPEED     = 32'h00030000,
    parameter logic [31:0] INIT_X        = 32'h01400000,
    parameter logic [31:0] INIT_Y        = 32'h00F00000,
    parameter logic [31:0] INIT_VX       = 32'h00010000,
    parameter logic [31:0] INIT_VY       = 32'h00008000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] vx,
    output logic [31:0] vy,
    output logic [31:0] px,
    output logic [31:0] py
);

    // Margins expressed as 16.16 positions for signed comparison.
    localparam logic signed [31:0] LEFT_LIM   = LEFT_MARGIN   * 65536;
    localparam logic signed [31:0] RIGHT_LIM  = RIGHT_MARGIN  * 65536;
    localparam logic signed [31:0] TOP_LIM    = TOP_MARGIN    * 65536;
    localparam logic signed [31:0] BOTTOM_LIM = BOTTOM_MARGIN * 65536;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_MAG   = 3'd2,
        ST_LIMIT = 3'd3,
        ST_MOVE  = 3'd4
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic signed [31:0] wvx_r;
    logic signed [31:0] wvy_r;
    logic signed [31:0] spd_r;

    logic signed [31:0] turn_vx_s;
    logic signed [31:0] turn_vy_s;
    logic signed [31:0] abs_x_s;
    logic signed [31:0] abs_y_s;
    logic signed [31:0] spd_next_s;
    logic signed [31:0] lim_vx_s;
    logic signed [31:0] lim_vy_s;

    // FSM state register; only advances on enabled edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else if (en) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state sequencing: fixed five-step loop.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE:  state_next_s = ST_TURN;
            ST_TURN:  state_next_s = ST_MAG;
            ST_MAG:   state_next_s = ST_LIMIT;
            ST_LIMIT: state_next_s = ST_MOVE;
            ST_MOVE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Margin turning; both rules of an axis are applied independently.
    always_comb begin
        turn_vx_s = wvx_r
                  + (($signed(x) < LEFT_LIM)   ? $signed(TURN_FACTOR) : 32'sd0)
                  - (($signed(x) > RIGHT_LIM)  ? $signed(TURN_FACTOR) : 32'sd0);
        turn_vy_s = wvy_r
                  + (($signed(y) < TOP_LIM)    ? $signed(TURN_FACTOR) : 32'sd0)
                  - (($signed(y) > BOTTOM_LIM) ? $signed(TURN_FACTOR) : 32'sd0);
    end

    // Alpha-max-beta-min speed estimate: max + min/2.
    always_comb begin
        abs_x_s = wvx_r[31] ? (32'sd0 - wvx_r) : wvx_r;
        abs_y_s = wvy_r[31] ? (32'sd0 - wvy_r) : wvy_r;
        if (abs_x_s >= abs_y_s) begin
            spd_next_s = abs_x_s + (abs_y_s >>> 1);
        end else begin
            spd_next_s = abs_y_s + (abs_x_s >>> 1);
        end
    end

    // Speed clamp: scale by 0.75 when too fast, by 1.25 when too slow.
    always_comb begin
        if (spd_r > $signed(MAX_SPEED)) begin
            lim_vx_s = wvx_r - (wvx_r >>> 2);
            lim_vy_s = wvy_r - (wvy_r >>> 2);
        end else if (spd_r < $signed(MIN_SPEED)) begin
            lim_vx_s = wvx_r + (wvx_r >>> 2);
            lim_vy_s = wvy_r + (wvy_r >>> 2);
        end else begin
            lim_vx_s = wvx_r;
            lim_vy_s = wvy_r;
        end
    end

    // Datapath: working registers per step; outputs change only in MOVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            x     <= INIT_X;
            y     <= INIT_Y;
            vx    <= INIT_VX;
            vy    <= INIT_VY;
            px    <= INIT_X;
            py    <= INIT_Y;
            wvx_r <= 32'sd0;
            wvy_r <= 32'sd0;
            spd_r <= 32'sd0;
        end else if (en) begin
            case (state_r)
                ST_IDLE: begin
                    wvx_r <= $signed(vx);
                    wvy_r <= $signed(vy);
                end
                ST_TURN: begin
                    wvx_r <= turn_vx_s;
                    wvy_r <= turn_vy_s;
                end
                ST_MAG: begin
                    spd_r <= spd_next_s;
                end
                ST_LIMIT: begin
                    wvx_r <= lim_vx_s;
                    wvy_r <= lim_vy_s;
                end
                ST_MOVE: begin
                    px <= x;
                    py <= y;
                    vx <= wvx_r;
                    vy <= wvy_r;
                    x  <= x + wvx_r;
                    y  <= y + wvy_r;
                end
                default: begin
                    wvx_r <= wvx_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boid_accelerator_core.sv
module tb_boid_accelerator_core;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] vx;
        logic [31:0] vy;
        logic [31:0] px;
        logic [31:0] py;
    } tuple_t;

    // Per-instance parameter sets: defaults, wide left margin, tight max clamp.
    int lm   [3] = '{100, 400, 100};
    int maxs [3] = '{32'h00060000, 32'h00060000, 32'h00008000};
    int mins [3] = '{32'h00030000, 32'h00030000, 0};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;

    logic [31:0] ox [3];
    logic [31:0] oy [3];
    logic [31:0] ovx[3];
    logic [31:0] ovy[3];
    logic [31:0] opx[3];
    logic [31:0] opy[3];

    int tests_run = 0;
    int failed    = 0;

    tuple_t exp_q [3][$];
    tuple_t mdl   [3];
    tuple_t prev  [3];
    int     en_cnt = 0;

    always #5 clk = ~clk;

    boid_accelerator_core dut0 (
        .clk(clk), .reset(reset), .en(en),
        .x(ox[0]), .y(oy[0]), .vx(ovx[0]), .vy(ovy[0]), .px(opx[0]), .py(opy[0])
    );

    boid_accelerator_core #(.LEFT_MARGIN(400)) dut1 (
        .clk(clk), .reset(reset), .en(en),
        .x(ox[1]), .y(oy[1]), .vx(ovx[1]), .vy(ovy[1]), .px(opx[1]), .py(opy[1])
    );

    boid_accelerator_core #(.MIN_SPEED(32'h00000000), .MAX_SPEED(32'h00008000)) dut2 (
        .clk(clk), .reset(reset), .en(en),
        .x(ox[2]), .y(oy[2]), .vx(ovx[2]), .vy(ovy[2]), .px(opx[2]), .py(opy[2])
    );

    function automatic tuple_t reset_tuple();
        tuple_t t;
        t.x  = 32'h01400000;
        t.y  = 32'h00F00000;
        t.vx = 32'h00010000;
        t.vy = 32'h00008000;
        t.px = 32'h01400000;
        t.py = 32'h00F00000;
        return t;
    endfunction

    // One complete boid update computed directly from the motion rules.
    function automatic tuple_t boid_step(tuple_t s, int idx);
        tuple_t n;
        int wx, wy, xi, yi, ax, ay, spd;
        xi = s.x;
        yi = s.y;
        wx = s.vx;
        wy = s.vy;
        if (xi < lm[idx] * 65536) wx += 32'h3333;
        if (xi > 540 * 65536)     wx -= 32'h3333;
        if (yi < 100 * 65536)     wy += 32'h3333;
        if (yi > 380 * 65536)     wy -= 32'h3333;
        ax  = (wx < 0) ? -wx : wx;
        ay  = (wy < 0) ? -wy : wy;
        spd = (ax >= ay) ? ax + (ay >>> 1) : ay + (ax >>> 1);
        if (spd > maxs[idx]) begin
            wx = wx - (wx >>> 2);
            wy = wy - (wy >>> 2);
        end else if (spd < mins[idx]) begin
            wx = wx + (wx >>> 2);
            wy = wy + (wy >>> 2);
        end
        n.px = s.x;
        n.py = s.y;
        n.vx = wx;
        n.vy = wy;
        n.x  = xi + wx;
        n.y  = yi + wy;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    task automatic chk_tuple(input string name, input tuple_t act, input tuple_t expv);
        tests_run++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got x=%08h y=%08h vx=%08h vy=%08h px=%08h py=%08h expected x=%08h y=%08h vx=%08h vy=%08h px=%08h py=%08h",
                     name, act.x, act.y, act.vx, act.vy, act.px, act.py,
                     expv.x, expv.y, expv.vx, expv.vy, expv.px, expv.py);
        end
    endtask

    // Drive inputs for the next edge and record the expected outcome of it.
    task automatic step(input bit r, input bit e);
        tuple_t nxt;
        bit     done;
        @(negedge clk);
        reset = r;
        en    = e;
        done  = 1'b0;
        if (r) begin
            en_cnt = 0;
        end else if (e) begin
            en_cnt++;
            if (en_cnt == 5) begin
                done   = 1'b1;
                en_cnt = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (r)         nxt = reset_tuple();
            else if (done) nxt = boid_step(mdl[i], i);
            else           nxt = mdl[i];
            if (nxt !== mdl[i]) exp_q[i].push_back(nxt);
            mdl[i] = nxt;
        end
    endtask

    function automatic tuple_t dut_out(int i);
        tuple_t t;
        t.x  = ox[i];
        t.y  = oy[i];
        t.vx = ovx[i];
        t.vy = ovy[i];
        t.px = opx[i];
        t.py = opy[i];
        return t;
    endfunction

    // Monitor: any output change must match the next queued expectation.
    initial begin
        tuple_t cur;
        tuple_t e;
        for (int i = 0; i < 3; i++) prev[i] = 'x;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                cur = dut_out(i);
                if (cur !== prev[i]) begin
                    if (exp_q[i].size() == 0) begin
                        tests_run++;
                        failed++;
                        $display("FAIL unexpected_change dut%0d: got x=%08h vx=%08h expected no change", i, cur.x, cur.vx);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk_tuple($sformatf("update dut%0d", i), cur, e);
                    end
                    prev[i] = cur;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) mdl[i] = 'x;

        // Reset held for five clocks.
        repeat (5) step(1'b1, 1'b0);
        @(posedge clk); #2;
        chk("reset_x",  ox[0],  32'h01400000);
        chk("reset_y",  oy[0],  32'h00F00000);
        chk("reset_vx", ovx[0], 32'h00010000);
        chk("reset_vy", ovy[0], 32'h00008000);
        chk("reset_px", opx[0], 32'h01400000);
        chk("reset_py", opy[0], 32'h00F00000);

        // First update: five enabled edges.
        repeat (5) step(1'b0, 1'b1);
        @(posedge clk); #2;
        chk("first_vx", ovx[0], 32'h00014000);
        chk("first_vy", ovy[0], 32'h0000A000);
        chk("first_x",  ox[0],  32'h01414000);
        chk("first_y",  oy[0],  32'h00F0A000);
        chk("first_px", opx[0], 32'h01400000);
        chk("first_py", opy[0], 32'h00F00000);
        chk("turn_vx",  ovx[1], 32'h00017FFF);
        chk("turn_vy",  ovy[1], 32'h0000A000);
        chk("turn_x",   ox[1],  32'h01417FFF);
        chk("clamp_vx", ovx[2], 32'h0000C000);
        chk("clamp_vy", ovy[2], 32'h00006000);
        chk("clamp_x",  ox[2],  32'h0140C000);
        chk("clamp_y",  oy[2],  32'h00F06000);

        // En gating mid-sequence.
        repeat (2)  step(1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0);
        repeat (3)  step(1'b0, 1'b1);

        // Reset while the FSM sits in LIMIT.
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        @(posedge clk); #2;
        chk("midreset_x",  ox[0],  32'h01400000);
        chk("midreset_vx", ovx[0], 32'h00010000);
        chk("midreset_px", opx[0], 32'h01400000);
        repeat (5) step(1'b0, 1'b1);

        // Randomized enable and occasional reset.
        repeat (1500) step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
        repeat (6) step(1'b0, 1'b1);
        @(posedge clk); #2;

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("queue_empty dut%0d", i), exp_q[i].size(), 32'd0);
            chk_tuple($sformatf("final dut%0d", i), dut_out(i), mdl[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/boid_accelerator_core.md
Name: boid_accelerator_core

Overview:
Single-boid motion engine for the VGA/M10k boids display. It holds one boid's position and velocity in signed 16.16 fixed point. On each update it applies screen-margin turning and a min/max speed clamp based on an alpha-max-beta-min magnitude estimate, then advances the position. It also exports the previous position so the drawing logic can erase the old pixel and draw the new one.

Parameters:
LEFT_MARGIN, 100, integer pixel x; when x < LEFT_MARGIN<<16, vx increases by TURN_FACTOR.
RIGHT_MARGIN, 540, integer pixel x; when x > RIGHT_MARGIN<<16, vx decreases by TURN_FACTOR.
TOP_MARGIN, 100, integer pixel y; when y < TOP_MARGIN<<16, vy increases by TURN_FACTOR.
BOTTOM_MARGIN, 380, integer pixel y; when y > BOTTOM_MARGIN<<16, vy decreases by TURN_FACTOR.
TURN_FACTOR, 32'h00003333, turn step, 16.16 (~0.2).
MAX_SPEED, 32'h00060000, upper speed bound, 16.16 (6.0).
MIN_SPEED, 32'h00030000, lower speed bound, 16.16 (3.0).
INIT_X, 32'h01400000, reset x (320.0).
INIT_Y, 32'h00F00000, reset y (240.0).
INIT_VX, 32'h00010000, reset vx (1.0).
INIT_VY, 32'h00008000, reset vy (0.5).

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  clock enable; FSM and registers advance only on edges where en=1.
x  out  32  current x position, signed 16.16 (pixel = x>>>16).
y  out  32  current y position, signed 16.16.
vx  out  32  current x velocity, signed 16.16.
vy  out  32  current y velocity, signed 16.16.
px  out  32  x position before the last update, signed 16.16.
py  out  32  y position before the last update, signed 16.16.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on port reset.
- Reset has priority over en. On reset, all outputs and state are set as follows:
  - x=INIT_X, y=INIT_Y, vx=INIT_VX, vy=INIT_VY, px=INIT_X, py=INIT_Y.
  - FSM=IDLE; working registers are cleared.
- When en=0, all registers hold, including the FSM.
- The FSM advances one state per enabled edge: IDLE -> TURN -> MAG -> LIMIT -> MOVE -> IDLE.
  - A full update takes 5 enabled edges.
  - Updates run back-to-back while en stays high.
- IDLE: copy vx and vy into working registers wvx and wvy.
- TURN: apply the margin rules listed in Parameters to wvx and wvy.
  - Compare against the current x and y; comparisons are signed.
  - The x and y axes are independent and can both turn in the same update.
- MAG: speed estimate spd = max(|wvx|,|wvy|) + (min(|wvx|,|wvy|) >>> 1).
  - abs is two's-complement negate.
  - When the two magnitudes are equal, either may be taken as max.
- LIMIT:
  - if spd > MAX_SPEED: wvx -= wvx>>>2 and wvy -= wvy>>>2 (scale by 0.75).
  - else if spd < MIN_SPEED: wvx += wvx>>>2 and wvy += wvy>>>2 (scale by 1.25).
  - else: wvx and wvy are unchanged.
  - Zero velocity stays zero.
- MOVE: on a single edge, px<=x, py<=y, vx<=wvx, vy<=wvy, x<=x+wvx, y<=y+wvy.
  - The six outputs change only on this edge and are otherwise stable.
- Arithmetic: all 32-bit two's-complement. Additions wrap with no saturation, and shifts are arithmetic.
- A reset asserted mid-sequence aborts the update: outputs return to reset values and the partially computed working velocity is discarded.

Test Plan:
- Reset: hold reset for 5 clocks -> x=01400000, y=00F00000, vx=00010000, vy=00008000, px=01400000, py=00F00000.
- First update, default parameters, en=1 -> after the 5th enabled edge following reset release: vx=00014000, vy=0000A000, x=01414000, y=00F0A000, px=01400000, py=00F00000. No output changes on the earlier 4 edges.
- Turn: LEFT_MARGIN=400, other parameters default -> the first update gives vx=00017FFF, vy=0000A000, x=01417FFF.
- Max clamp: MIN_SPEED=0, MAX_SPEED=00008000 -> spd=00014000 > max, so vx=0000C000, vy=00006000, x=0140C000, y=00F06000.
- En gating: hold en=0 for 20 clocks mid-sequence -> all outputs and the FSM state are frozen. Raising en resumes with identical final results.
- Reset mid-update: assert reset during LIMIT -> the next edge shows reset values, and the next update completes 5 enabled edges after reset is released.
